// File: rtl/im_prefetch_buffer.sv
// Instruction prefetch buffer: sequential IM fetch into a PC-tagged FWFT FIFO, flush/restart on redirect.
// Optional same-cycle bypass of an IM response into an empty FIFO when PF_BYPASS_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_BOOT   | first cycle after reset release, no fetch issued
// S_RUN    | issue sequential fetches while FIFO credits remain
// S_REDIRECT | fetch target re-latched, response slot dropped, no issue
module im_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IM_enable,
  output logic [31:0] IM_address,
  input  logic [31:0] IM_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_REDIRECT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   last_inst;
  logic [31:0]   last_pc;
  logic          inflight;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];

  logic          fifo_empty;
  logic          redirect_act;
  logic          resp_keep;
  logic          byp_avail;
  logic          bypass_take;
  logic          push;
  logic          pop;
  logic [AW+1:0] credits_used;

  assign fifo_empty   = (count == '0);
  assign redirect_act = redirect_valid && (state != S_BOOT);
  assign resp_keep    = inflight && !redirect_act;
  // Credits count only registered occupancy plus the response in flight.
  assign credits_used = {1'b0, count} + {{(AW+1){1'b0}}, inflight};

`ifdef PF_BYPASS_EN
  assign byp_avail = fifo_empty && resp_keep;
`else
  assign byp_avail = 1'b0;
`endif

  assign bypass_take = byp_avail && inst_ready;
  assign push        = resp_keep && !bypass_take;
  assign pop         = !fifo_empty && inst_ready && !redirect_act;
  assign inst_valid  = !fifo_empty || byp_avail;
  assign IM_address  = fetch_pc;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_BOOT;
    else      state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:     state_nxt = S_RUN;
      S_RUN:      state_nxt = redirect_act ? S_REDIRECT : S_RUN;
      S_REDIRECT: state_nxt = redirect_act ? S_REDIRECT : S_RUN;
      default:    state_nxt = S_BOOT;
    endcase
  end

  // outputs
  always_comb begin
    IM_enable = 1'b0;
    case (state)
      S_RUN:   IM_enable = !redirect_act && (credits_used < DEPTH_W);
      default: IM_enable = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= IM_enable;
      if (redirect_act) begin
        fetch_pc <= redirect_pc & ~32'h3;
      end else if (IM_enable) begin
        fetch_pc <= fetch_pc + 32'd4;
        resp_pc  <= fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_act) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= IM_out;
      mem_pc[wr_ptr]   <= resp_pc;
    end
  end

  // inst/inst_pc keep showing the last presented word while nothing is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_inst <= '0;
      last_pc   <= '0;
    end else if (inst_valid) begin
      last_inst <= inst;
      last_pc   <= inst_pc;
    end
  end

  always_comb begin
    inst    = last_inst;
    inst_pc = last_pc;
    if (!fifo_empty) begin
      inst    = mem_inst[rd_ptr];
      inst_pc = mem_pc[rd_ptr];
    end else if (byp_avail) begin
      inst    = IM_out;
      inst_pc = resp_pc;
    end
  end

endmodule

// File: doc/im_prefetch_buffer.md
Name: im_prefetch_buffer

Overview:
- Instruction prefetch stage between the synchronous instruction memory (IM) and the CPU fetch stage.
- Issues sequential word reads to IM and buffers returned instructions, tagged with their PC, in a small FIFO.
- Presents instructions to the CPU with a valid/ready handshake.
- Flushes and restarts on a redirect (branch or jump) from the CPU.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; the block is held in reset while low.
- IM_enable  output  1  IM read request this cycle.
- IM_address  output  32  byte address of the request; bits [1:0] always 0.
- IM_out  input  32  IM read data, valid the cycle after a request.
- redirect_valid  input  1  CPU requests a flush and restart.
- redirect_pc  input  32  restart address; bits [1:0] ignored and treated as 0.
- inst_valid  output  1  inst/inst_pc hold a valid instruction.
- inst  output  32  instruction word.
- inst_pc  output  32  PC of inst.
- inst_ready  input  1  CPU accepts inst this cycle.

Behaviour:
- Reset values of outputs:
  - IM_enable=0, IM_address=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- Reset values of internal state:
  - FIFO empty, in-flight flag=0, fetch_pc=RESET_PC, state=BOOT.
- State BOOT: lasts one cycle after rst deasserts; no issue; always goes to RUN.
- State RUN:
  - IM_enable=1 when (count + inflight) < DEPTH.
  - IM_address=fetch_pc.
  - On issue: fetch_pc += 4 (wraps mod 2^32) and inflight<=1; otherwise inflight<=0.
- IM response timing:
  - Data for a request issued in cycle N is on IM_out in cycle N+1.
  - If not discarded, it is pushed with its PC at the end of cycle N+1.
- Output side:
  - FIFO is first-word-fall-through: inst_valid = !empty; inst/inst_pc show the head entry.
  - Pop occurs when inst_valid && inst_ready.
- Credit accounting: a pop in the same cycle does not free a credit. Count is the registered occupancy, so full never overflows.
- Simultaneous push and pop: legal; count is unchanged.
- Redirect (redirect_valid=1, any state except BOOT):
  - Takes priority over pop and push.
  - FIFO is emptied at the cycle end.
  - Any response arriving next cycle is discarded.
  - fetch_pc<=redirect_pc & ~3; state goes to REDIRECT.
  - IM_enable=0 in the redirect cycle.
- State REDIRECT: one cycle; IM_enable=0; the pending response is dropped; goes to RUN.
- Redirect asserted in REDIRECT: re-latches the newer redirect_pc and stays in REDIRECT one more cycle.
- Redirect-to-first-fetch latency: first fetch of the redirect target is 2 cycles after redirect_valid.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight data is never pushed.
- inst/inst_pc when inst_valid=0: hold their last value (0 after reset).

Optional Feature:
- Macro: PF_BYPASS_EN.
- When defined:
  - If the FIFO is empty and an undiscarded response arrives, inst_valid=1 in that same cycle with inst=IM_out and inst_pc=its PC.
  - If inst_ready=1 that cycle, the word is consumed and not pushed; otherwise it is pushed normally.
  - Reset-to-first-valid drops from 4 to 3 cycles.
- When undefined:
  - Responses always pass through the FIFO; first inst_valid comes 4 cycles after rst deasserts.

Test Plan:
- Reset then inst_ready=1 constant, IM word i = 32'h1000_0000+i:
  - Without bypass, inst_valid rises in cycle 4.
  - Sequence is inst_pc=0,4,8,..., inst=32'h1000_0000, 32'h1000_0001, ...
  - One instruction per cycle thereafter.
- inst_ready=0 for 20 cycles, DEPTH=4:
  - Exactly 4 IM_enable pulses occur, then IM_enable stays 0.
  - Raising inst_ready drains PCs 0,4,8,12 in order; fetching resumes at 16.
- redirect_valid with redirect_pc=32'h0000_0103 while 3 entries are buffered and a request is in flight:
  - FIFO empties next cycle and the in-flight word is never presented.
  - IM_enable=0 for 2 cycles, then IM_address=32'h0000_0100.
  - First delivered inst_pc=32'h100.
- Back-to-back redirects to 32'h40 then 32'h80:
  - No instruction from 32'h40 is ever presented.
  - First issued address is 32'h80.
- fetch_pc=32'hFFFF_FFFC with continuous fetch:
  - Next IM_address is 32'h0000_0000.
  - inst_pc sequence is ...FFFC, 0000_0000.
- rst pulled low mid-stream with 2 entries buffered:
  - inst_valid=0 and IM_enable=0 immediately.
  - After release, fetch restarts at RESET_PC with the FIFO empty.
